// File: rtl/fft_stage_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// fft_sched_pkg
// Shared definitions for the FFT stage scheduler:
//   LOG2N_DEFAULT  default log2 of the transform length (N = 8)
//   sched_state_e  scheduler FSM state encoding
// ----------------------------------------------------------------------------
package fft_sched_pkg;

  localparam int LOG2N_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } sched_state_e;

endpackage

// File: rtl/fft_stage_scheduler_if.sv
// ----------------------------------------------------------------------------
// fft_stage_scheduler_if
// Bundles the host request, butterfly handshake and status signals of the FFT
// stage scheduler.
//   start     host -> sched   request a full transform
//   bf_done   bfly -> sched   current butterfly written back (1-cycle pulse)
//   bf_start  sched -> bfly   launch one butterfly (1-cycle pulse)
//   addr_a    sched -> bfly   upper-leg address
//   addr_b    sched -> bfly   lower-leg address
//   tw_idx    sched -> bfly   twiddle ROM index
//   stage     sched -> host   current stage number
//   busy      sched -> host   transform in progress
//   done      sched -> host   transform complete (1-cycle pulse)
// Modport master is the scheduler side; slave is the host/butterfly side.
// ----------------------------------------------------------------------------
interface fft_stage_scheduler_if
  import fft_sched_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT
);

  logic                       start;
  logic                       bf_done;
  logic                       bf_start;
  logic [LOG2N-1:0]           addr_a;
  logic [LOG2N-1:0]           addr_b;
  logic [LOG2N-2:0]           tw_idx;
  logic [$clog2(LOG2N)-1:0]   stage;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, bf_done,
    output bf_start, addr_a, addr_b, tw_idx, stage, busy, done
  );

  modport slave (
    output start, bf_done,
    input  bf_start, addr_a, addr_b, tw_idx, stage, busy, done
  );

endinterface

// File: rtl/fft_stage_scheduler_addr_gen.sv
// ----------------------------------------------------------------------------
// fft_addr_gen
// Combinational radix-2 butterfly address / twiddle generator.
//   stage_i   stage number s (0..LOG2N-1)
//   k_i       butterfly index within the stage (0..N/2-1)
//   addr_a_o  upper leg: k with a zero inserted at bit position s
//   addr_b_o  lower leg: addr_a_o with bit s set
//   tw_idx_o  twiddle index: (k mod 2^s) scaled to the N/2-entry ROM
// ----------------------------------------------------------------------------
module fft_addr_gen
  import fft_sched_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT
) (
  input  logic [$clog2(LOG2N)-1:0] stage_i,
  input  logic [LOG2N-2:0]         k_i,
  output logic [LOG2N-1:0]         addr_a_o,
  output logic [LOG2N-1:0]         addr_b_o,
  output logic [LOG2N-2:0]         tw_idx_o
);

  logic [LOG2N-2:0] lo_mask;
  logic [LOG2N-2:0] lo;
  logic [LOG2N-2:0] hi;
  logic [LOG2N-1:0] b_bit;

  always_comb begin
    lo_mask  = ~({(LOG2N-1){1'b1}} << stage_i);
    lo       = k_i & lo_mask;
    hi       = k_i >> stage_i;
    // Splitting k at bit s and shifting the high part up by one leaves bit s
    // of addr_a clear, so addr_a + 2^s reduces to setting that bit.
    addr_a_o = ({1'b0, hi} << stage_i << 1) | {1'b0, lo};
    b_bit    = {{(LOG2N-1){1'b0}}, 1'b1} << stage_i;
    addr_b_o = addr_a_o | b_bit;
    tw_idx_o = lo << (LOG2N - 1 - int'(stage_i));
  end

endmodule

// File: rtl/fft_stage_scheduler.sv
// ----------------------------------------------------------------------------
// fft_stage_scheduler
// Sequences the (N/2)*LOG2N radix-2 butterflies of an N-point in-place FFT,
// one at a time, handshaking with an external butterfly unit.
//   clk_sys_i  system clock, rising edge
//   rst_i      synchronous active-high reset
//   bus        fft_stage_scheduler_if.master (start/bf_done in; bf_start,
//              addr_a, addr_b, tw_idx, stage, busy, done out)
// LOG2N legal range 2..10.
//
//   state  | meaning
//   IDLE   | waiting for start; outputs quiet
//   ISSUE  | bf_start high for one cycle with the butterfly's addresses
//   WAIT   | holding addresses until bf_done returns
//   FINISH | done high for one cycle, then back to IDLE
// ----------------------------------------------------------------------------
module fft_stage_scheduler
  import fft_sched_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_i,
  fft_stage_scheduler_if.master bus
);

  localparam int              SW         = $clog2(LOG2N);
  localparam int              KW         = LOG2N - 1;
  localparam logic [SW-1:0]   LAST_STAGE = SW'(LOG2N - 1);

  sched_state_e      state_q;
  logic [SW-1:0]     stage_q, stage_d;
  logic [KW-1:0]     k_q, k_d;
  logic              bf_start_q;
  logic              busy_q;
  logic              done_q;
  logic [LOG2N-1:0]  addr_a_q, addr_b_q;
  logic [KW-1:0]     tw_idx_q;
  logic [LOG2N-1:0]  gen_addr_a, gen_addr_b;
  logic [KW-1:0]     gen_tw_idx;
  logic              last_bf;

  assign last_bf = (stage_q == LAST_STAGE) && (&k_q);

  // Counter value the next ISSUE will use: (0,0) from IDLE, otherwise the
  // successor of the butterfly in flight. Only loaded on entry to ISSUE.
  always_comb begin
    stage_d = stage_q;
    k_d     = k_q;
    if (state_q == IDLE) begin
      stage_d = '0;
      k_d     = '0;
    end else if (&k_q) begin
      stage_d = stage_q + 1'b1;
      k_d     = '0;
    end else begin
      k_d     = k_q + 1'b1;
    end
  end

  // Addresses are generated for the upcoming butterfly and registered on
  // ISSUE entry, so they stay frozen through WAIT and read zero after reset.
  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .stage_i  (stage_d),
    .k_i      (k_d),
    .addr_a_o (gen_addr_a),
    .addr_b_o (gen_addr_b),
    .tw_idx_o (gen_tw_idx)
  );

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      k_q        <= '0;
      bf_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= ISSUE;
            stage_q    <= stage_d;
            k_q        <= k_d;
            addr_a_q   <= gen_addr_a;
            addr_b_q   <= gen_addr_b;
            tw_idx_q   <= gen_tw_idx;
            bf_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ISSUE: begin
          // bf_done here belongs to no butterfly yet and is dropped.
          bf_start_q <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (bus.bf_done) begin
            if (last_bf) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              stage_q    <= stage_d;
              k_q        <= k_d;
              addr_a_q   <= gen_addr_a;
              addr_b_q   <= gen_addr_b;
              tw_idx_q   <= gen_tw_idx;
              bf_start_q <= 1'b1;
            end
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.bf_start = bf_start_q;
  assign bus.addr_a   = addr_a_q;
  assign bus.addr_b   = addr_b_q;
  assign bus.tw_idx   = tw_idx_q;
  assign bus.stage    = stage_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fft_stage_scheduler
// Directed bench for fft_stage_scheduler: an N=8 instance for the full
// sequence, slow/noisy handshake and mid-transform reset, plus an N=4
// instance for the start-held / start-with-reset behaviour.
// ----------------------------------------------------------------------------
module tb_fft_stage_scheduler;

  logic clk;
  logic rst3;
  logic rst2;
  int   vectors;
  int   miscompares;

  fft_stage_scheduler_if #(.LOG2N(3)) if3();
  fft_stage_scheduler_if #(.LOG2N(2)) if2();

  fft_stage_scheduler #(.LOG2N(3)) dut3 (
    .clk_sys_i (clk),
    .rst_i     (rst3),
    .bus       (if3.master)
  );

  fft_stage_scheduler #(.LOG2N(2)) dut2 (
    .clk_sys_i (clk),
    .rst_i     (rst2),
    .bus       (if2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived butterfly order for N=8.
  logic [2:0] exp_a3  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [2:0] exp_b3  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [1:0] exp_tw3 [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] exp_st3 [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};

  // Hand-derived butterfly order for N=4.
  logic [1:0] exp_a2  [4] = '{2'd0, 2'd2, 2'd0, 2'd1};
  logic [1:0] exp_b2  [4] = '{2'd1, 2'd3, 2'd2, 2'd3};
  logic       exp_tw2 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       exp_st2 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst3 = 1'b1;
    rst2 = 1'b1;
    if3.start = 1'b0; if3.bf_done = 1'b0;
    if2.start = 1'b0; if2.bf_done = 1'b0;
    tick(); tick();
    rst3 = 1'b0;
    rst2 = 1'b0;
    vectors++; if (if3.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %0b want 0", if3.busy); end
    vectors++; if (if3.done !== 1'b0) begin miscompares++; $display("FAIL reset done got %0b want 0", if3.done); end
    vectors++; if (if3.bf_start !== 1'b0) begin miscompares++; $display("FAIL reset bf_start got %0b want 0", if3.bf_start); end
    vectors++; if (if3.addr_a !== 3'd0) begin miscompares++; $display("FAIL reset addr_a got %0d want 0", if3.addr_a); end
    vectors++; if (if3.addr_b !== 3'd0) begin miscompares++; $display("FAIL reset addr_b got %0d want 0", if3.addr_b); end
    vectors++; if (if3.tw_idx !== 2'd0) begin miscompares++; $display("FAIL reset tw_idx got %0d want 0", if3.tw_idx); end
    vectors++; if (if3.stage !== 2'd0) begin miscompares++; $display("FAIL reset stage got %0d want 0", if3.stage); end
    vectors++; if (if2.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy2 got %0b want 0", if2.busy); end
  endtask

  // delay = WAIT cycles until bf_done (1 = returned the cycle after ISSUE).
  // noise = drive start and bf_done during the ISSUE cycle, start during WAIT.
  task automatic test_transform(input int delay, input bit noise, input string tag);
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    for (int n = 0; n < 12; n++) begin
      vectors++; if (if3.bf_start !== 1'b1) begin miscompares++; $display("FAIL %s bf_start n=%0d got %0b want 1", tag, n, if3.bf_start); end
      vectors++; if (if3.addr_a !== exp_a3[n]) begin miscompares++; $display("FAIL %s addr_a n=%0d got %0d want %0d", tag, n, if3.addr_a, exp_a3[n]); end
      vectors++; if (if3.addr_b !== exp_b3[n]) begin miscompares++; $display("FAIL %s addr_b n=%0d got %0d want %0d", tag, n, if3.addr_b, exp_b3[n]); end
      vectors++; if (if3.tw_idx !== exp_tw3[n]) begin miscompares++; $display("FAIL %s tw_idx n=%0d got %0d want %0d", tag, n, if3.tw_idx, exp_tw3[n]); end
      vectors++; if (if3.stage !== exp_st3[n]) begin miscompares++; $display("FAIL %s stage n=%0d got %0d want %0d", tag, n, if3.stage, exp_st3[n]); end
      if (noise) begin
        if3.bf_done = 1'b1;
        if3.start   = 1'b1;
      end
      tick();
      if3.bf_done = 1'b0;
      for (int d = 1; d < delay; d++) begin
        if (noise) if3.start = ~if3.start;
        vectors++; if (if3.bf_start !== 1'b0) begin miscompares++; $display("FAIL %s extra bf_start n=%0d d=%0d got %0b want 0", tag, n, d, if3.bf_start); end
        tick();
      end
      if3.start = 1'b0;
      // Last WAIT cycle: addresses must still hold the issued butterfly.
      vectors++; if (if3.addr_a !== exp_a3[n] || if3.addr_b !== exp_b3[n] || if3.tw_idx !== exp_tw3[n] || if3.stage !== exp_st3[n])
        begin miscompares++; $display("FAIL %s hold n=%0d got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d", tag, n,
          if3.addr_a, if3.addr_b, if3.tw_idx, if3.stage, exp_a3[n], exp_b3[n], exp_tw3[n], exp_st3[n]); end
      vectors++; if (if3.bf_start !== 1'b0 || if3.busy !== 1'b1) begin miscompares++; $display("FAIL %s wait n=%0d got bf_start=%0b busy=%0b want 0/1", tag, n, if3.bf_start, if3.busy); end
      if3.bf_done = 1'b1;
      tick();
      if3.bf_done = 1'b0;
      vectors++; if (if3.done !== (n == 11)) begin miscompares++; $display("FAIL %s done n=%0d got %0b want %0b", tag, n, if3.done, (n == 11)); end
    end
    vectors++; if (if3.busy !== 1'b1 || if3.bf_start !== 1'b0) begin miscompares++; $display("FAIL %s finish got busy=%0b bf_start=%0b want 1/0", tag, if3.busy, if3.bf_start); end
    tick();
    vectors++; if (if3.done !== 1'b0 || if3.busy !== 1'b0 || if3.bf_start !== 1'b0)
      begin miscompares++; $display("FAIL %s idle got done=%0b busy=%0b bf_start=%0b want 0/0/0", tag, if3.done, if3.busy, if3.bf_start); end
    // bf_done arriving in IDLE must not start anything.
    if3.bf_done = 1'b1;
    tick();
    if3.bf_done = 1'b0;
    tick();
    vectors++; if (if3.busy !== 1'b0 || if3.bf_start !== 1'b0) begin miscompares++; $display("FAIL %s idle bf_done got busy=%0b bf_start=%0b want 0/0", tag, if3.busy, if3.bf_start); end
  endtask

  task automatic test_mid_reset();
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if3.bf_done = 1'b1;
      tick();
      if3.bf_done = 1'b0;
    end
    vectors++; if (if3.addr_a !== 3'd4 || if3.addr_b !== 3'd6 || if3.stage !== 2'd1 || if3.bf_start !== 1'b1)
      begin miscompares++; $display("FAIL midrst pre got a=%0d b=%0d st=%0d bs=%0b want 4/6/1/1", if3.addr_a, if3.addr_b, if3.stage, if3.bf_start); end
    tick();
    // In WAIT at stage 1, k 2: reset beats bf_done and start.
    rst3 = 1'b1;
    if3.bf_done = 1'b1;
    if3.start = 1'b1;
    tick();
    rst3 = 1'b0;
    if3.bf_done = 1'b0;
    if3.start = 1'b0;
    vectors++; if (if3.busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy got %0b want 0", if3.busy); end
    vectors++; if (if3.bf_start !== 1'b0 || if3.done !== 1'b0) begin miscompares++; $display("FAIL midrst pulses got bs=%0b done=%0b want 0/0", if3.bf_start, if3.done); end
    vectors++; if (if3.addr_a !== 3'd0 || if3.addr_b !== 3'd0 || if3.tw_idx !== 2'd0 || if3.stage !== 2'd0)
      begin miscompares++; $display("FAIL midrst outs got a=%0d b=%0d tw=%0d st=%0d want 0/0/0/0", if3.addr_a, if3.addr_b, if3.tw_idx, if3.stage); end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (if3.done !== 1'b0 || if3.busy !== 1'b0) begin miscompares++; $display("FAIL midrst quiet c=%0d got done=%0b busy=%0b want 0/0", c, if3.done, if3.busy); end
    end
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    vectors++; if (if3.bf_start !== 1'b1 || if3.addr_a !== 3'd0 || if3.addr_b !== 3'd1 || if3.stage !== 2'd0)
      begin miscompares++; $display("FAIL midrst restart got bs=%0b a=%0d b=%0d st=%0d want 1/0/1/0", if3.bf_start, if3.addr_a, if3.addr_b, if3.stage); end
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
  endtask

  task automatic test_start_held();
    if2.start = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      vectors++; if (if2.bf_start !== 1'b1 || if2.addr_a !== exp_a2[n] || if2.addr_b !== exp_b2[n] || if2.tw_idx !== exp_tw2[n] || if2.stage !== exp_st2[n])
        begin miscompares++; $display("FAIL held n=%0d got bs=%0b a=%0d b=%0d tw=%0d st=%0d want 1/%0d/%0d/%0d/%0d", n,
          if2.bf_start, if2.addr_a, if2.addr_b, if2.tw_idx, if2.stage, exp_a2[n], exp_b2[n], exp_tw2[n], exp_st2[n]); end
      tick();
      if2.bf_done = 1'b1;
      tick();
      if2.bf_done = 1'b0;
      vectors++; if (if2.done !== (n == 3)) begin miscompares++; $display("FAIL held done n=%0d got %0b want %0b", n, if2.done, (n == 3)); end
    end
    tick();
    vectors++; if (if2.busy !== 1'b0 || if2.bf_start !== 1'b0 || if2.done !== 1'b0)
      begin miscompares++; $display("FAIL held idle got busy=%0b bs=%0b done=%0b want 0/0/0", if2.busy, if2.bf_start, if2.done); end
    tick();
    vectors++; if (if2.bf_start !== 1'b1 || if2.busy !== 1'b1 || if2.addr_a !== 2'd0 || if2.addr_b !== 2'd1)
      begin miscompares++; $display("FAIL held restart got bs=%0b busy=%0b a=%0d b=%0d want 1/1/0/1", if2.bf_start, if2.busy, if2.addr_a, if2.addr_b); end
    rst2 = 1'b1;
    tick();
    vectors++; if (if2.busy !== 1'b0) begin miscompares++; $display("FAIL held abort busy got %0b want 0", if2.busy); end
    tick();
    vectors++; if (if2.busy !== 1'b0 || if2.bf_start !== 1'b0) begin miscompares++; $display("FAIL held start+reset got busy=%0b bs=%0b want 0/0", if2.busy, if2.bf_start); end
    rst2 = 1'b0;
    if2.start = 1'b0;
    tick();
    vectors++; if (if2.busy !== 1'b0 || if2.done !== 1'b0) begin miscompares++; $display("FAIL held release got busy=%0b done=%0b want 0/0", if2.busy, if2.done); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_transform(1, 1'b0, "nominal");
    test_transform(5, 1'b1, "slow_noisy");
    test_mid_reset();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
